// File: rtl/four_bit_ud_counter.sv
// 4-bit up/down counter with an integrated hexadecimal 7-segment decoder.
// Counter clears asynchronously on an active-low reset.
module four_bit_ud_counter #(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       x,
   output logic [3:0] out,
   output logic [6:0] seg
);

   logic [3:0] cnt;
   logic [6:0] glyph;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (x) begin
         cnt <= cnt + 4'd1;
      end else begin
         cnt <= cnt - 4'd1;
      end
   end

   assign out = cnt;

   // Segment order abcdefg, a on the MSB; 1 = lit before polarity is applied.
   always_comb begin
      glyph = 7'b1111110;
      case (cnt)
         4'h0: glyph = 7'b1111110;
         4'h1: glyph = 7'b0110000;
         4'h2: glyph = 7'b1101101;
         4'h3: glyph = 7'b1111001;
         4'h4: glyph = 7'b0110011;
         4'h5: glyph = 7'b1011011;
         4'h6: glyph = 7'b1011111;
         4'h7: glyph = 7'b1110000;
         4'h8: glyph = 7'b1111111;
         4'h9: glyph = 7'b1111011;
         4'hA: glyph = 7'b1110111;
         4'hB: glyph = 7'b0011111;
         4'hC: glyph = 7'b1001110;
         4'hD: glyph = 7'b0111101;
         4'hE: glyph = 7'b1001111;
         4'hF: glyph = 7'b1000111;
         default: glyph = 7'b1111110;
      endcase
   end

   assign seg = SEG_ACTIVE_LOW ? ~glyph : glyph;

endmodule

// File: tb/tb_four_bit_ud_counter.sv
// Bench for four_bit_ud_counter: both segment polarities run side by side
// against an arithmetic count model and a glyph lookup table.
module tb_four_bit_ud_counter;

   logic       clk;
   logic       reset;
   logic       x;
   logic [3:0] out;
   logic [6:0] seg;
   logic [3:0] out_ca;
   logic [6:0] seg_ca;

   int vectors;
   int miscompares;
   int model;
   logic [6:0] glyph_tab [16];

   four_bit_ud_counter #(.SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .reset(reset), .x(x), .out(out), .seg(seg)
   );

   four_bit_ud_counter #(.SEG_ACTIVE_LOW(1'b1)) dut_ca (
      .clk(clk), .reset(reset), .x(x), .out(out_ca), .seg(seg_ca)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   // Advance one edge and update the model from the rules: +1/-1 modulo 16.
   task automatic edge_step();
      @(posedge clk);
      if (reset) model = (model + (x ? 1 : 15)) % 16;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      x     = 1'b1;
      model = 0;
      #2 reset = 1'b0;
      #3;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (out !== 4'd0 || seg !== 7'b1111110 || out_ca !== 4'd0 || seg_ca !== 7'b0000001) begin
            miscompares++;
            $display("FAIL reset[%0d]: out=%h seg=%b out_ca=%h seg_ca=%b, want out=0 seg=1111110 seg_ca=0000001",
                     i, out, seg, out_ca, seg_ca);
         end
         #10;
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_up_count();
      x = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         edge_step();
         vectors++;
         if (out !== 4'(i) || out !== 4'(model) || seg !== glyph_tab[i] || seg_ca !== ~glyph_tab[i]) begin
            miscompares++;
            $display("FAIL up_count[%0d]: out=%h seg=%b seg_ca=%b, want out=%h seg=%b", i, out, seg, seg_ca,
                     4'(i), glyph_tab[i]);
         end
      end
      vectors++;
      if (seg !== 7'b1110000) begin
         miscompares++;
         $display("FAIL up_count_seg7: seg=%b, want 1110000", seg);
      end
   endtask

   task automatic test_up_wrap();
      logic [3:0] want [3];
      want[0] = 4'd15; want[1] = 4'd0; want[2] = 4'd1;
      x = 1'b1;
      while (model != 14) edge_step();
      vectors++;
      if (out !== 4'd14) begin
         miscompares++;
         $display("FAIL up_wrap_start: out=%h, want e", out);
      end
      for (int i = 0; i < 3; i++) begin
         edge_step();
         vectors++;
         if (out !== want[i] || out_ca !== want[i] || seg !== glyph_tab[want[i]]) begin
            miscompares++;
            $display("FAIL up_wrap[%0d]: out=%h seg=%b, want out=%h seg=%b", i, out, seg, want[i],
                     glyph_tab[want[i]]);
         end
         if (i == 0) begin
            vectors++;
            if (seg !== 7'b1000111 || seg_ca !== 7'b0111000) begin
               miscompares++;
               $display("FAIL up_wrap_seg15: seg=%b seg_ca=%b, want 1000111/0111000", seg, seg_ca);
            end
         end
      end
   endtask

   task automatic test_down_wrap();
      logic [3:0] want [4];
      want[0] = 4'd1; want[1] = 4'd0; want[2] = 4'd15; want[3] = 4'd14;
      x = 1'b1;
      while (model != 2) edge_step();
      @(negedge clk);
      x = 1'b0;
      for (int i = 0; i < 4; i++) begin
         edge_step();
         vectors++;
         if (out !== want[i] || out !== 4'(model) || seg !== glyph_tab[want[i]] || seg_ca !== ~glyph_tab[want[i]]) begin
            miscompares++;
            $display("FAIL down_wrap[%0d]: out=%h seg=%b, want out=%h seg=%b", i, out, seg, want[i],
                     glyph_tab[want[i]]);
         end
      end
   endtask

   task automatic test_async_reset();
      x = 1'b0;
      while (model != 9) edge_step();
      @(negedge clk);
      #5 reset = 1'b0;
      #1;
      model = 0;
      vectors++;
      if (out !== 4'd0 || out_ca !== 4'd0 || seg !== 7'b1111110) begin
         miscompares++;
         $display("FAIL async_reset: out=%h out_ca=%h seg=%b, want 0/0/1111110", out, out_ca, seg);
      end
      @(negedge clk);
      reset = 1'b1;
      x = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         edge_step();
         vectors++;
         if (out !== 4'(i) || out !== 4'(model)) begin
            miscompares++;
            $display("FAIL async_resume[%0d]: out=%h, want %h", i, out, 4'(i));
         end
      end
   endtask

   task automatic test_decoder_sweep();
      @(negedge clk);
      reset = 1'b0;
      model = 0;
      #2 reset = 1'b1;
      x = 1'b1;
      for (int v = 0; v < 16; v++) begin
         if (v != 0) edge_step();
         vectors++;
         if (out !== 4'(v) || seg !== glyph_tab[v] || seg_ca !== ~glyph_tab[v]) begin
            miscompares++;
            $display("FAIL decoder[%0d]: out=%h seg=%b seg_ca=%b, want seg=%b seg_ca=%b", v, out, seg,
                     seg_ca, glyph_tab[v], ~glyph_tab[v]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         x = 1'($urandom_range(1, 0));
         if ($urandom_range(19, 0) == 0) begin
            #3 reset = 1'b0;
            model = 0;
            #2;
            vectors++;
            if (out !== 4'd0 || seg !== glyph_tab[0]) begin
               miscompares++;
               $display("FAIL random_reset[%0d]: out=%h seg=%b, want 0/%b", i, out, seg, glyph_tab[0]);
            end
            #3 reset = 1'b1;
         end
         edge_step();
         vectors++;
         if (out !== 4'(model) || out_ca !== 4'(model) || seg !== glyph_tab[model]
             || seg_ca !== ~glyph_tab[model]) begin
            miscompares++;
            $display("FAIL random[%0d]: out=%h seg=%b seg_ca=%b, want out=%h seg=%b", i, out, seg, seg_ca,
                     4'(model), glyph_tab[model]);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      glyph_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
      test_reset();
      test_up_count();
      test_up_wrap();
      test_down_wrap();
      test_async_reset();
      test_decoder_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
